// File: rtl/mux_pkg.sv
// mux_pkg: shared FSM state type and select-width helper for the PUF serializer.
package mux_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/mux_nto1.sv
// mux_nto1: combinational N:1 bit select; codes at or above N_IN yield 0.
module mux_nto1
  import mux_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int SEL_W = clog2_min1(N_IN)
) (
  input  logic [N_IN-1:0]  data,
  input  logic [SEL_W-1:0] sel,
  output logic             out
);
  always_comb begin
    out = 1'b0;
    for (int i = 0; i < N_IN; i++) out = (sel == SEL_W'(i)) ? data[i] : out;
  end
endmodule

// File: rtl/mux_serializer.sv
// mux_serializer: captures an N_IN-bit word on load and streams it one bit per
// valid/ready transfer, LSB-first or MSB-first as chosen at load time.
module mux_serializer
  import mux_pkg::*;
#(
  parameter int N_IN = 16,
  localparam int SEL_W = clog2_min1(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [N_IN-1:0]  din,
  input  logic             msb_first,
  output logic             busy,
  output logic             dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [SEL_W-1:0] sel,
  output logic             done
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);
  state_e            state_q, state_d;
  logic [N_IN-1:0]   shadow_q, shadow_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              order_q, order_d;
  logic              bit_sel;
  logic              last;
  mux_nto1 #(.N_IN(N_IN), .SEL_W(SEL_W)) u_mux (
    .data(shadow_q),
    .sel (sel_q),
    .out (bit_sel)
  );
  // Terminal index is checked before stepping so sel never wraps.
  assign last = order_q ? (sel_q == '0) : (sel_q == LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      sel_q    <= '0;
      order_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      order_q  <= order_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    order_d  = order_q;
    case (state_q)
      IDLE: if (load) begin
        state_d  = SHIFT;
        shadow_d = din;
        order_d  = msb_first;
        sel_d    = msb_first ? LAST : '0;
      end
      SHIFT: if (dout_ready) begin
        state_d = last ? DONE : SHIFT;
        sel_d   = last ? sel_q : (order_q ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1));
      end
      default: state_d = IDLE;
    endcase
  end
  assign dout_valid = (state_q == SHIFT);
  assign dout       = dout_valid & bit_sel;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign sel        = sel_q;
endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer: directed and random streams on 16-bit and 5-bit serializers.
module tb_mux_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load16 = 1'b0, msb16 = 1'b0, rdy16 = 1'b0;
  logic [15:0] din16 = '0;
  logic        busy16, dout16, vld16, done16;
  logic [3:0]  sel16;
  logic        load5 = 1'b0, msb5 = 1'b0, rdy5 = 1'b0;
  logic [4:0]  din5 = '0;
  logic        busy5, dout5, vld5, done5;
  logic [2:0]  sel5;
  int          tests = 0, fails = 0, cyc = 0;
  logic [15:0] got16;
  logic [4:0]  got5;

  mux_serializer #(.N_IN(16)) dut16 (
    .clk(clk), .rst(rst), .load(load16), .din(din16), .msb_first(msb16),
    .busy(busy16), .dout(dout16), .dout_valid(vld16), .dout_ready(rdy16),
    .sel(sel16), .done(done16)
  );
  mux_serializer #(.N_IN(5)) dut5 (
    .clk(clk), .rst(rst), .load(load5), .din(din5), .msb_first(msb5),
    .busy(busy5), .dout(dout5), .dout_valid(vld5), .dout_ready(rdy5),
    .sel(sel5), .done(done5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the k-th accepted bit is din[k] (LSB-first) or din[N-1-k] (MSB-first).
  // mode 0: ready always 1; 1: ready pattern 1,0,0,1,0,1...; 2: random ready.
  task automatic stream16(input logic [15:0] d, input logic m, input int mode,
                          input logic inject, output logic [15:0] got);
    int idx, n, c0, exp_sel;
    logic r, prev_r, prev_d;
    logic [5:0] pat;
    pat = 6'b101001;
    idx = 0; n = 0; prev_r = 1'b1; prev_d = 1'b0; got = '0;
    c0 = cyc;
    load16 = 1'b1; din16 = d; msb16 = m;
    tick();
    load16 = 1'b0; din16 = 16'($urandom); msb16 = 1'($urandom);
    while (idx < 16 && n < 200) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[n % 6] : 1'($urandom);
      rdy16 = r;
      load16 = inject && (n == 4);
      din16 = inject ? 16'hFFFF : din16;
      exp_sel = m ? 15 - idx : idx;
      check("valid16", vld16, 1);
      check("busy16", busy16, 1);
      check("sel16", sel16, exp_sel);
      check("dout16", dout16, d[exp_sel]);
      if (!prev_r) check("hold16", dout16, prev_d);
      if (r) begin
        got[idx] = dout16;
        idx++;
      end
      prev_r = r; prev_d = dout16;
      tick();
      n++;
    end
    check("xfers16", idx, 16);
    rdy16 = 1'b0; load16 = 1'b0;
    check("done16", done16, 1);
    check("done_busy16", busy16, 1);
    check("done_valid16", vld16, 0);
    check("done_dout16", dout16, 0);
    if (mode == 0) check("latency16", cyc - c0, 17);
    tick();
    check("idle_done16", done16, 0);
    check("idle_busy16", busy16, 0);
  endtask

  task automatic stream5(input logic [4:0] d, input logic m, output logic [4:0] got, output int max_sel);
    int idx, n, exp_sel;
    logic r;
    idx = 0; n = 0; got = '0; max_sel = 0;
    load5 = 1'b1; din5 = d; msb5 = m;
    tick();
    load5 = 1'b0; din5 = 5'($urandom);
    while (idx < 5 && n < 100) begin
      r = 1'($urandom);
      rdy5 = r;
      exp_sel = m ? 4 - idx : idx;
      check("valid5", vld5, 1);
      check("sel5", sel5, exp_sel);
      check("dout5", dout5, d[exp_sel]);
      if (int'(sel5) > max_sel) max_sel = int'(sel5);
      if (r) begin
        got[idx] = dout5;
        idx++;
      end
      tick();
      n++;
    end
    check("xfers5", idx, 5);
    rdy5 = 1'b0;
    check("done5", done5, 1);
    check("done_valid5", vld5, 0);
    tick();
    check("idle_busy5", busy5, 0);
    check("idle_done5", done5, 0);
  endtask

  initial begin
    logic [15:0] d, exp16;
    logic [4:0]  d5, exp5;
    logic        m;
    int          mx;
    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_busy16", busy16, 0);
      check("rst_valid16", vld16, 0);
      check("rst_done16", done16, 0);
      check("rst_sel16", sel16, 0);
      check("rst_dout16", dout16, 0);
      check("rst_busy5", busy5, 0);
      check("rst_sel5", sel5, 0);
    end
    // LSB-first: sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
    stream16(16'hA5C3, 1'b0, 0, 1'b0, got16);
    check("lsb_seq", got16, 16'hA5C3);
    // MSB-first: sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1
    stream16(16'hA5C3, 1'b1, 0, 1'b0, got16);
    check("msb_seq", got16, 16'hC3A5);
    // Backpressure plus an ignored mid-word load
    stream16(16'hA5C3, 1'b0, 1, 1'b1, got16);
    check("bp_seq", got16, 16'hA5C3);
    tick();
    check("no_restart", busy16, 0);
    // Reset after 5 transfers
    load16 = 1'b1; din16 = 16'h5A5A; msb16 = 1'b0;
    tick();
    load16 = 1'b0; rdy16 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_sel", sel16, 5);
    rst = 1'b1; rdy16 = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy16, 0);
    check("mid_rst_valid", vld16, 0);
    check("mid_rst_done", done16, 0);
    check("mid_rst_sel", sel16, 0);
    tick();
    check("mid_rst_nodone", done16, 0);
    stream16(16'h0001, 1'b0, 0, 1'b0, got16);
    check("post_rst_seq", got16, 16'h0001);
    // Random words, orders and backpressure
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      m = 1'($urandom);
      for (int k = 0; k < 16; k++) exp16[k] = m ? d[15 - k] : d[k];
      stream16(d, m, 2, 1'($urandom), got16);
      check("rand_seq16", got16, exp16);
    end
    // Odd width: 10110 LSB-first -> 0,1,1,0,1
    stream5(5'b10110, 1'b0, got5, mx);
    check("odd_seq", got5, 5'b10110);
    check("odd_maxsel", mx, 4);
    for (int i = 0; i < 6; i++) begin
      d5 = 5'($urandom);
      m = 1'($urandom);
      for (int k = 0; k < 5; k++) exp5[k] = m ? d5[4 - k] : d5[k];
      stream5(d5, m, got5, mx);
      check("rand_seq5", got5, exp5);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux_serializer.md
Name: mux_serializer

Overview:
- Parametrised N-to-1 serializer for PUF response bits; successor to the fixed 16:1 select mux.
- Captures an N_IN-bit parallel vector on a load strobe, then steps an internal select counter through every input, presenting one bit per accepted transfer on a valid/ready serial port.
- Sits between the PUF response capture stage and the serial link/UART framer.
- Bit order is selectable per load: LSB-first or MSB-first.

Parameters:
- N_IN, 16, number of parallel inputs; legal range 1..256.
- SEL_W, max(1, clog2(N_IN)), select counter width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- load  in  1  capture request; honoured only in IDLE.
- din  in  N_IN  parallel response vector, sampled when a load is accepted.
- msb_first  in  1  order select, sampled with din: 0 = bit 0 first, 1 = bit N_IN-1 first.
- busy  out  1  high in SHIFT and DONE.
- dout  out  1  current serial bit; meaningful only while dout_valid=1.
- dout_valid  out  1  serial bit available.
- dout_ready  in  1  downstream accepts dout; a transfer occurs when dout_valid & dout_ready.
- sel  out  SEL_W  current select index, for debug and coverage.
- done  out  1  one-cycle pulse after the last transfer.

Behaviour:
- States:
  - IDLE -> SHIFT on load.
  - SHIFT -> DONE on the final transfer.
  - DONE -> IDLE unconditionally after 1 cycle.
- Reset, synchronous, evaluated before all other logic:
  - state = IDLE; shadow register = 0; sel = 0; order flag = 0.
  - busy = 0, dout_valid = 0, dout = 0, done = 0.
  - Reset mid-SHIFT abandons the word; no done pulse.
- Load accept (IDLE & load):
  - shadow <= din; order <= msb_first.
  - sel <= 0 if msb_first=0, else N_IN-1.
  - Next cycle: state = SHIFT, dout_valid = 1. Load-to-first-valid latency = 1 cycle.
- Load while busy: ignored; no error flag; shadow is unchanged.
- SHIFT:
  - dout = shadow[sel], driven from registered state only (no combinational path from din or dout_ready).
  - dout_valid = 1 throughout.
  - Each transfer advances sel by +1 (LSB-first) or -1 (MSB-first).
- Final transfer: sel = N_IN-1 (LSB-first) or sel = 0 (MSB-first).
  - Next cycle: state = DONE, dout_valid = 0, done = 1, busy = 1.
  - The cycle after that: IDLE, busy = 0; a new load is accepted there.
- Backpressure:
  - dout_ready=0 holds dout, sel and dout_valid stable; no bit is skipped or repeated.
  - dout_ready may toggle every cycle.
- Throughput: with dout_ready held high, N_IN transfers in N_IN consecutive cycles.
  - Full word period = N_IN + 2 cycles: load cycle + N_IN SHIFT cycles + DONE.
- sel never wraps: no increment past N_IN-1, no decrement below 0; the terminal check happens before update.
- N_IN=1: a single transfer, then DONE; SEL_W = 1, sel stays 0.
- Non-power-of-two N_IN: sel values >= N_IN are unreachable; the mux defaults to 0 for those codes.
- In IDLE and DONE, dout = 0.

Decomposition:
- Shared package mux_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - clog2-with-minimum-1 function used for SEL_W.
- Sub-module mux_nto1: purely combinational, parametrised N:1 select.
  - Ports: data[N_IN-1:0], sel[SEL_W-1:0], out.
  - Out-of-range sel yields 0.
  - Instantiated once on the shadow register.
- The FSM, counter and shadow register live in mux_serializer.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, load=0 -> busy=0, dout_valid=0, done=0, sel=0 on every cycle after reset.
- LSB-first streaming: N_IN=16, din=16'hA5C3, msb_first=0, dout_ready=1.
  - Accepted dout sequence = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - done pulses exactly 17 cycles after the load cycle.
- MSB-first streaming: same din, msb_first=1 -> sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; sel counts 15 down to 0.
- Backpressure and ignored load:
  - din=16'hA5C3, LSB-first; drive dout_ready with pattern 1,0,0,1,0,1... -> same bit sequence as the LSB-first case, and dout is stable on every cycle where ready=0.
  - load=1 with din=16'hFFFF mid-SHIFT -> ignored; the output stream is unchanged.
- Reset mid-operation: rst=1 after 5 transfers -> next cycle busy=0, dout_valid=0, no done pulse; a subsequent load of 16'h0001 streams 1 then fifteen 0s.
- Odd width: N_IN=5, din=5'b10110, LSB-first -> 0,1,1,0,1; sel reaches 4 maximum; done follows the 5th transfer.
